// File: rtl/display_pkg.sv
// Shared display-adaptor types and sizes for system memory, fetch and frame buffer.
package display_pkg;

    localparam int unsigned SM_DEPTH = 100;
    localparam int unsigned SM_AW    = 7;
    localparam int unsigned PIX_DW   = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_WAIT,
        ST_ISSUE,
        ST_CAPTURE,
        ST_WRITE,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/sysmem_frame_fetch.sv
// Frame fetch initiator: strobes the system-memory load, reads every word in
// address order and forwards each word to the frame buffer over a ready-gated port.
module sysmem_frame_fetch
    import display_pkg::*;
#(
    parameter int unsigned DEPTH = SM_DEPTH,
    parameter int unsigned AW    = SM_AW,
    parameter int unsigned DW    = PIX_DW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    output logic          Busy,
    output logic          Done,
    output logic [1:0]    FrameCnt,
    output logic          WESM,
    output logic          RESM,
    output logic [AW-1:0] AddrSM,
    input  logic [DW-1:0] SMData,
    output logic          WEFB,
    output logic [AW-1:0] AddrFB,
    output logic [DW-1:0] FBData,
    input  logic          FBReady
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    frame_cnt_d;

    logic          busy_d, done_d, wesm_d, resm_d, wefb_d;
    logic [AW-1:0] addrsm_d, addrfb_d;
    logic [DW-1:0] fbdata_d;

    // Next-state logic; outputs are decoded from the next state so they can be registered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        frame_cnt_d = FrameCnt;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD:      state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                // memory read has had the whole ISSUE+CAPTURE window to settle
                data_d  = SMData;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (FBReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_DONE;
                        frame_cnt_d = FrameCnt + 2'd1;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        wesm_d   = (state_d == ST_LOAD);
        resm_d   = (state_d == ST_ISSUE) || (state_d == ST_CAPTURE);
        addrsm_d = resm_d ? idx_d : AddrSM;
        wefb_d   = (state_d == ST_WRITE);
        addrfb_d = wefb_d ? idx_d : '0;
        fbdata_d = wefb_d ? data_d : '0;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            FrameCnt <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            WESM     <= 1'b0;
            RESM     <= 1'b0;
            AddrSM   <= '0;
            WEFB     <= 1'b0;
            AddrFB   <= '0;
            FBData   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            FrameCnt <= frame_cnt_d;
            Busy     <= busy_d;
            Done     <= done_d;
            WESM     <= wesm_d;
            RESM     <= resm_d;
            AddrSM   <= addrsm_d;
            WEFB     <= wefb_d;
            AddrFB   <= addrfb_d;
            FBData   <= fbdata_d;
        end
    end

endmodule
